// File: rtl/ahb_line_queue.sv
// AHB-Lite slave that queues line-segment commands (x1,y1,x2,y2) for a downstream drawing engine.
// A commit to a full queue either stalls the bus until a pop or is dropped with a sticky overflow.
module ahb_line_queue #(
  parameter int unsigned COORD_W       = 9,
  parameter int unsigned DEPTH         = 8,
  parameter bit          BLOCK_ON_FULL = 1'b1
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               HSEL,
  input  logic [31:0]        HADDR,
  input  logic [1:0]         HTRANS,
  input  logic               HWRITE,
  input  logic [2:0]         HSIZE,
  input  logic [31:0]        HWDATA,
  input  logic               HREADY,
  output logic [31:0]        HRDATA,
  output logic               HREADYOUT,
  output logic [COORD_W-1:0] x1,
  output logic [COORD_W-1:0] y1,
  output logic [COORD_W-1:0] x2,
  output logic [COORD_W-1:0] y2,
  output logic               DataValid,
  input  logic               DataReady
);

  localparam int unsigned PtrW  = $clog2(DEPTH);
  localparam int unsigned CntW  = PtrW + 1;
  localparam int unsigned PairW = 2 * COORD_W;
  localparam int unsigned EntW  = 2 * PairW;

  typedef enum logic [1:0] {
    RegP1     = 2'd0,
    RegP2     = 2'd1,
    RegStatus = 2'd2,
    RegCtrl   = 2'd3
  } reg_e;

  // Pairs are held as {y, x}; a queue entry is {p2, p1} = {y2, x2, y1, x1}.
  function automatic logic [PairW-1:0] unpack_pair(input logic [31:0] d);
    return {d[16 +: COORD_W], d[COORD_W-1:0]};
  endfunction

  function automatic logic [31:0] pack_pair(input logic [PairW-1:0] p);
    logic [31:0] r;
    r                 = '0;
    r[COORD_W-1:0]    = p[COORD_W-1:0];
    r[16 +: COORD_W]  = p[PairW-1:COORD_W];
    return r;
  endfunction

  // Data-phase registers
  logic        dp_valid_q;
  reg_e        dp_addr_q;
  logic        dp_write_q;
  logic        dp_size_ok_q;

  // Queue state
  logic [EntW-1:0]  mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             ovf_q, ovf_d;
  logic [PairW-1:0] p1_q, p1_d;
  logic [PairW-1:0] p2_q, p2_d;
  logic [31:0]      hrdata_q;
  logic [31:0]      rdata_d;

  logic addr_valid, rd_req;
  logic wr_ok, wr_p1, wr_p2, wr_ctrl;
  logic empty, full, pop, stall, p2_done, push, drop, flush, clr_ovf;
  logic [EntW-1:0] head;

  assign addr_valid = HSEL & HREADY & HTRANS[1];
  assign rd_req     = addr_valid & ~HWRITE;

  assign wr_ok   = dp_valid_q & dp_write_q & dp_size_ok_q;
  assign wr_p1   = wr_ok & (dp_addr_q == RegP1);
  assign wr_p2   = wr_ok & (dp_addr_q == RegP2);
  assign wr_ctrl = wr_ok & (dp_addr_q == RegCtrl);

  assign empty = (count_q == '0);
  assign full  = (count_q == CntW'(DEPTH));
  assign pop   = ~empty & DataReady;

  // A full-queue commit only waits when nothing drains in the same cycle.
  assign stall   = BLOCK_ON_FULL & wr_p2 & full & ~pop;
  assign p2_done = wr_p2 & ~stall;
  assign push    = p2_done & (~full | pop);
  assign drop    = p2_done & full & ~pop;
  assign flush   = wr_ctrl & HWDATA[0];
  assign clr_ovf = wr_ctrl & HWDATA[1];

  assign HREADYOUT = ~stall;
  assign HRDATA    = hrdata_q;

  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      if (push && !pop) begin
        count_d = count_q + CntW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CntW'(1);
      end
    end
  end

  always_comb begin
    ovf_d = ovf_q | drop;
    if (clr_ovf) ovf_d = 1'b0;
    p1_d = wr_p1   ? unpack_pair(HWDATA) : p1_q;
    p2_d = p2_done ? unpack_pair(HWDATA) : p2_q;
  end

  // Read data is taken from next-state values so it shows the state at the start of the data phase.
  always_comb begin
    rdata_d = '0;
    case (reg_e'(HADDR[3:2]))
      RegP1: rdata_d = pack_pair(p1_d);
      RegP2: rdata_d = pack_pair(p2_d);
      RegStatus: begin
        rdata_d[CntW-1:0] = count_d;
        rdata_d[16]       = (count_d == '0);
        rdata_d[17]       = (count_d == CntW'(DEPTH));
        rdata_d[18]       = ovf_d;
      end
      default: rdata_d = '0;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      dp_valid_q   <= 1'b0;
      dp_addr_q    <= RegP1;
      dp_write_q   <= 1'b0;
      dp_size_ok_q <= 1'b0;
      hrdata_q     <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      ovf_q        <= 1'b0;
      p1_q         <= '0;
      p2_q         <= '0;
    end else begin
      if (HREADY) begin
        dp_valid_q   <= addr_valid;
        dp_addr_q    <= reg_e'(HADDR[3:2]);
        dp_write_q   <= HWRITE;
        dp_size_ok_q <= (HSIZE == 3'b010);
        hrdata_q     <= rd_req ? rdata_d : '0;
      end
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= {p2_d, p1_q};
  end

  assign head      = empty ? '0 : mem_q[rd_ptr_q];
  assign DataValid = ~empty;
  assign x1        = head[COORD_W-1:0];
  assign y1        = head[PairW-1:COORD_W];
  assign x2        = head[PairW +: COORD_W];
  assign y2        = head[EntW-1 -: COORD_W];

  logic unused_bits;
  assign unused_bits = ^{HADDR[31:4], HADDR[1:0], HTRANS[0]};

endmodule
